boot_loader: RTL

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_pkg.sv | 23 ++
 rtl/rx_word_assembler.sv | 30 +++
 rtl/boot_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader: FSM states,
// memory access length encoding and header geometry.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } boot_state_t;

  localparam logic [1:0] LEN_WORD  = 2'b10;
  localparam int         HDR_BYTES = 4;
  localparam int         HDR_WIDTH = 8 * HDR_BYTES;

  // A program length is usable when it is non-zero and fits the memory window.
  function automatic logic len_ok(input logic [HDR_WIDTH-1:0] n, input int max_words);
    return (n != '0) && (n <= HDR_WIDTH'(max_words));
  endfunction

endpackage

// File: rtl/rx_word_assembler.sv
// Packs a byte stream into 32-bit little-endian words; word_valid marks the
// cycle in which the 4th byte is accepted, with the complete word on 'word'.
module rx_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] acc;
  logic [1:0]  byte_cnt;

  assign word       = {in_data, acc};
  assign word_valid = in_valid && (byte_cnt == 2'd3);

  // New bytes enter at the top so byte 0 ends up in the least significant lane.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc      <= '0;
      byte_cnt <= '0;
    end else if (in_valid) begin
      acc      <= {in_data, acc[23:8]};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Serial boot loader: receives a length header and program words, writes
// them to memory, releases the CPU, then requests a memory dump on halt or
// timeout. Define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_WORDS  = 1024,
  parameter int          RUN_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [31:0] o_mem_addr_w,
  output logic [31:0] o_mem_data_w,
  output logic [1:0]  o_mem_len_w,
  output logic        o_mem_write_en,
  output logic        o_cpu_rstn,
  input  logic        i_cpu_halt,
  output logic        o_dump_mem,
  output logic        o_done,
  output logic        o_err,
  output logic        o_timeout,
  output logic [2:0]  o_dbg_state
);

  boot_state_t        state;
  logic [31:0]        n_words;
  logic [31:0]        word_idx;
  logic [31:0]        run_cnt;
  logic               data_done;
  logic               accept;
  logic               asm_valid;
  logic               asm_clr;
  logic [31:0]        word;
  logic               word_valid;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]         xsum;
`endif

  // Handshake: a byte moves on a rising edge where i_rx_valid and o_rx_ready
  // are both high; the host may hold i_rx_valid low for any number of cycles.
`ifdef BOOT_LOADER_CHECKSUM_EN
  assign o_rx_ready = (state == ST_HDR) || (state == ST_LOAD);
`else
  assign o_rx_ready = (state == ST_HDR) || (state == ST_LOAD && !data_done);
`endif

  assign accept      = i_rx_valid && o_rx_ready;
  assign asm_valid   = accept && !data_done;
  assign asm_clr     = !((state == ST_HDR) || (state == ST_LOAD));
  assign o_mem_len_w = LEN_WORD;
  assign o_dbg_state = state;

  rx_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .in_valid   (asm_valid),
    .in_data    (i_rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_HDR;
      n_words        <= '0;
      word_idx       <= '0;
      run_cnt        <= '0;
      data_done      <= 1'b0;
      o_mem_write_en <= 1'b0;
      o_mem_addr_w   <= '0;
      o_mem_data_w   <= '0;
      o_cpu_rstn     <= 1'b0;
      o_dump_mem     <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_timeout      <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      xsum           <= '0;
`endif
    end else begin
      o_mem_write_en <= 1'b0;
      o_dump_mem     <= 1'b0;
      case (state)
        ST_HDR: begin
          if (word_valid) begin
            n_words <= word;
            if (len_ok(word, MAX_WORDS)) begin
              state <= ST_LOAD;
            end else begin
              state <= ST_ERR;
              o_err <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (word_valid) begin
            o_mem_write_en <= 1'b1;
            o_mem_addr_w   <= BASE_ADDR + (word_idx << 2);
            o_mem_data_w   <= word;
            word_idx       <= word_idx + 32'd1;
            if (word_idx == n_words - 32'd1) begin
              data_done <= 1'b1;
            end
          end
`ifdef BOOT_LOADER_CHECKSUM_EN
          if (asm_valid) begin
            xsum <= xsum ^ i_rx_data;
          end
          // The byte after the last data word is the checksum, not data.
          if (data_done && accept) begin
            if (i_rx_data == xsum) begin
              state      <= ST_RUN;
              o_cpu_rstn <= 1'b1;
              run_cnt    <= '0;
            end else begin
              state <= ST_ERR;
              o_err <= 1'b1;
            end
          end
`else
          // data_done is set by the last word's write; release the CPU one cycle later.
          if (data_done) begin
            state      <= ST_RUN;
            o_cpu_rstn <= 1'b1;
            run_cnt    <= '0;
          end
`endif
        end

        ST_RUN: begin
          run_cnt <= run_cnt + 32'd1;
          if (i_cpu_halt) begin
            state      <= ST_DUMP;
            o_dump_mem <= 1'b1;
          end else if (run_cnt == 32'(RUN_CYCLES - 1)) begin
            state      <= ST_DUMP;
            o_dump_mem <= 1'b1;
            o_timeout  <= 1'b1;
          end
        end

        ST_DUMP: begin
          state      <= ST_DONE;
          o_cpu_rstn <= 1'b0;
          o_done     <= 1'b1;
        end

        ST_DONE: begin
          state <= ST_DONE;
        end

        ST_ERR: begin
          state <= ST_ERR;
        end

        default: begin
          state <= ST_ERR;
          o_err <= 1'b1;
        end
      endcase
    end
  end

endmodule
